// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : IF-1 next-PC generator (flush / ID correction / IF-2 predictor /
//            PC+4), with BTB-init hold and a pending slot for stalled redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter bit          USE_BP   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_mispredict,
    input  logic [31:0] id_correct_pc,
    input  logic        bp_ready,
    input  logic        bp_predict_if2,
    input  logic [31:0] bp_target_if2,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        if2_valid
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_pc_valid;
    logic        w_pc_valid_nxt;
    logic        r_if2_valid;
    logic        w_if2_valid_nxt;
    logic        r_pend_v;
    logic        w_pend_v_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_nxt;
    logic        r_pend_is_flush;
    logic        w_pend_is_flush_nxt;

    logic        w_boot_done;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_bp_taken;

    assign w_boot_done   = USE_BP ? bp_ready : 1'b1;
    assign w_redirect    = flush | id_mispredict;
    assign w_redirect_pc = flush ? flush_pc : id_correct_pc;
    assign w_bp_taken    = r_if2_valid & bp_predict_if2 & USE_BP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_BOOT;
            r_pc            <= RESET_PC;
            r_pc_valid      <= 1'b0;
            r_if2_valid     <= 1'b0;
            r_pend_v        <= 1'b0;
            r_pend_pc       <= 32'd0;
            r_pend_is_flush <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_pc_valid      <= w_pc_valid_nxt;
            r_if2_valid     <= w_if2_valid_nxt;
            r_pend_v        <= w_pend_v_nxt;
            r_pend_pc       <= w_pend_pc_nxt;
            r_pend_is_flush <= w_pend_is_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_pc_valid_nxt      = r_pc_valid;
        w_if2_valid_nxt     = r_if2_valid;
        w_pend_v_nxt        = r_pend_v;
        w_pend_pc_nxt       = r_pend_pc;
        w_pend_is_flush_nxt = r_pend_is_flush;

        case (r_state)
            S_BOOT: begin
                // PC already sits at RESET_PC; leaving BOOT only makes it valid.
                if (w_boot_done) begin
                    w_state_nxt    = S_RUN;
                    w_pc_valid_nxt = 1'b1;
                end
            end

            S_RUN: begin
                if (w_redirect) begin
                    if (stall) begin
                        w_state_nxt         = S_PEND;
                        w_pend_v_nxt        = 1'b1;
                        w_pend_pc_nxt       = w_redirect_pc;
                        w_pend_is_flush_nxt = flush;
                    end else begin
                        w_pc_nxt        = w_redirect_pc;
                        w_if2_valid_nxt = 1'b0;
                    end
                end else if (!stall) begin
                    // After a predicted-taken redirect the IF-2 slot's BTB data is
                    // stale, so its prediction is masked for one cycle.
                    if (w_bp_taken) begin
                        w_pc_nxt        = bp_target_if2;
                        w_if2_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt        = r_pc + c_PC_STEP;
                        w_if2_valid_nxt = r_pc_valid;
                    end
                end
            end

            S_PEND: begin
                // A pending flush belongs to an older instruction than any later
                // mispredict, so only a flush may replace it.
                if (flush) begin
                    w_pend_pc_nxt       = flush_pc;
                    w_pend_is_flush_nxt = 1'b1;
                end else if (id_mispredict && !r_pend_is_flush) begin
                    w_pend_pc_nxt = id_correct_pc;
                end
                if (!stall) begin
                    w_state_nxt     = S_RUN;
                    w_pc_nxt        = w_pend_pc_nxt;
                    w_pend_v_nxt    = 1'b0;
                    w_if2_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign if2_valid = r_if2_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Self-checking bench for fetch_pc_gen: directed scenarios plus a
//            randomized run against a behavioural next-PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        id_mispredict = 1'b0;
    logic [31:0] id_correct_pc = 32'd0;
    logic        bp_ready = 1'b0;
    logic        bp_predict_if2 = 1'b0;
    logic [31:0] bp_target_if2 = 32'd0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        if2_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: where fetch is, whether IF-2 may predict, and one
    // outstanding redirect that waits out a stall.
    bit          m_running;
    logic [31:0] m_pc;
    bit          m_if2v;
    bit          m_has_pend;
    bit          m_pend_flush;
    logic [31:0] m_pend_pc;

    fetch_pc_gen #(
        .RESET_PC (c_RESET_PC),
        .USE_BP   (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .id_mispredict  (id_mispredict),
        .id_correct_pc  (id_correct_pc),
        .bp_ready       (bp_ready),
        .bp_predict_if2 (bp_predict_if2),
        .bp_target_if2  (bp_target_if2),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .if2_valid      (if2_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_running    = 0;
        m_pc         = c_RESET_PC;
        m_if2v       = 0;
        m_has_pend   = 0;
        m_pend_flush = 0;
        m_pend_pc    = 32'd0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!m_running) begin
            if (bp_ready) m_running = 1;
        end else if (m_has_pend) begin
            if (flush) begin
                m_pend_pc    = flush_pc;
                m_pend_flush = 1;
            end else if (id_mispredict && !m_pend_flush) begin
                m_pend_pc = id_correct_pc;
            end
            if (!stall) begin
                m_pc       = m_pend_pc;
                m_if2v     = 0;
                m_has_pend = 0;
            end
        end else if (flush || id_mispredict) begin
            if (stall) begin
                m_has_pend   = 1;
                m_pend_flush = flush;
                m_pend_pc    = flush ? flush_pc : id_correct_pc;
            end else begin
                m_pc   = flush ? flush_pc : id_correct_pc;
                m_if2v = 0;
            end
        end else if (!stall) begin
            if (m_if2v && bp_predict_if2) begin
                m_pc   = bp_target_if2;
                m_if2v = 0;
            end else begin
                m_pc   = m_pc + 32'd4;
                m_if2v = 1;
            end
        end
    endtask

    task automatic clear_inputs();
        stall          = 0;
        flush          = 0;
        id_mispredict  = 0;
        bp_predict_if2 = 0;
    endtask

    // Inputs are set while clk is low; outputs are observed at the next negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        bp_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (pc !== c_RESET_PC || pc_valid !== 1'b0 || if2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h pc_valid=%b if2_valid=%b, want %h 0 0", pc, pc_valid, if2_valid, c_RESET_PC);
        end
    endtask

    task automatic test_boot();
        flush = 1; flush_pc = 32'h1234_5678;
        for (int i = 0; i < 1023; i++) begin
            cycle();
            n_checks++;
            if (pc !== c_RESET_PC || pc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL boot_hold[%0d]: pc=%h pc_valid=%b, want %h 0", i, pc, pc_valid, c_RESET_PC);
            end
        end
        flush = 0;
        bp_ready = 1;
        cycle();
        bp_ready = 0;
        n_checks++;
        if (pc !== c_RESET_PC || pc_valid !== 1'b1 || if2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_first: pc=%h pc_valid=%b if2_valid=%b, want %h 1 0", pc, pc_valid, if2_valid, c_RESET_PC);
        end
        cycle();
        n_checks++;
        if (pc !== 32'hBFC0_0004 || if2_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_seq1: pc=%h if2_valid=%b, want bfc00004 1", pc, if2_valid);
        end
        cycle();
        n_checks++;
        if (pc !== 32'hBFC0_0008 || pc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_seq2: pc=%h pc_valid=%b, want bfc00008 1", pc, pc_valid);
        end
    endtask

    task automatic test_predict();
        flush = 1; flush_pc = 32'h8000_000C;
        cycle();
        flush = 0;
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0010 || if2_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL predict_setup: pc=%h if2_valid=%b, want 80000010 1", pc, if2_valid);
        end
        bp_predict_if2 = 1; bp_target_if2 = 32'h8000_0100;
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0100 || if2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL predict_taken: pc=%h if2_valid=%b, want 80000100 0", pc, if2_valid);
        end
        bp_target_if2 = 32'h8000_0500;
        cycle();
        bp_predict_if2 = 0;
        n_checks++;
        if (pc !== 32'h8000_0104 || if2_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL predict_gated: pc=%h if2_valid=%b, want 80000104 1", pc, if2_valid);
        end
    endtask

    task automatic test_flush_vs_mispredict();
        flush = 1; flush_pc = 32'h8000_0180;
        id_mispredict = 1; id_correct_pc = 32'h8000_0200;
        cycle();
        clear_inputs();
        n_checks++;
        if (pc !== 32'h8000_0180 || if2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority: pc=%h if2_valid=%b, want 80000180 0", pc, if2_valid);
        end
        cycle();
    endtask

    // Two stalled redirects in the given order; the flush must win either way.
    task automatic test_stalled_redirect(input bit flush_first);
        logic [31:0] hold_pc;
        hold_pc = pc;
        stall = 1;
        for (int c = 1; c <= 3; c++) begin
            flush = 0; id_mispredict = 0;
            if ((c == 1) == flush_first) begin
                if (c <= 2) begin flush = 1; flush_pc = 32'h8000_0180; end
            end else if (c <= 2) begin
                id_mispredict = 1; id_correct_pc = 32'h8000_0300;
            end
            cycle();
            n_checks++;
            if (pc !== hold_pc || pc_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold(ff=%0d,c=%0d): pc=%h pc_valid=%b, want %h 1", flush_first, c, pc, pc_valid, hold_pc);
            end
        end
        clear_inputs();
        cycle();
        n_checks++;
        if (pc !== 32'h8000_0180 || if2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release(ff=%0d): pc=%h if2_valid=%b, want 80000180 0", flush_first, pc, if2_valid);
        end
        cycle();
    endtask

    task automatic test_wrap_and_async_reset();
        flush = 1; flush_pc = 32'hFFFF_FFFC;
        cycle();
        clear_inputs();
        cycle();
        n_checks++;
        if (pc !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h, want 00000000", pc);
        end
        stall = 1; id_mispredict = 1; id_correct_pc = 32'h8000_0400;
        cycle();
        id_mispredict = 0;
        n_checks++;
        if (dut.r_pend_v !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_entry: pend_v=%b, want 1", dut.r_pend_v);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (pc !== c_RESET_PC || pc_valid !== 1'b0 || if2_valid !== 1'b0 || dut.r_pend_v !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h pc_valid=%b if2_valid=%b pend_v=%b, want %h 0 0 0",
                     pc, pc_valid, if2_valid, dut.r_pend_v, c_RESET_PC);
        end
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        bp_ready = 1;
        cycle();
        cycle();
        n_checks++;
        if (pc !== 32'hBFC0_0004 || pc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_drops_pend: pc=%h pc_valid=%b, want bfc00004 1", pc, pc_valid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            stall          = ($urandom_range(99) < 30);
            flush          = ($urandom_range(99) < 8);
            id_mispredict  = ($urandom_range(99) < 12);
            bp_predict_if2 = ($urandom_range(99) < 50);
            bp_ready       = ($urandom_range(99) < 30);
            flush_pc       = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : $urandom;
            id_correct_pc  = $urandom;
            bp_target_if2  = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom;
            cycle();
            n_checks++;
            if (pc !== m_pc || pc_valid !== m_running || if2_valid !== m_if2v) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h pc_valid=%b if2_valid=%b, want %h %b %b",
                         i, pc, pc_valid, if2_valid, m_pc, m_running, m_if2v);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_boot();
        test_predict();
        test_flush_vs_mispredict();
        test_stalled_redirect(1'b1);
        test_stalled_redirect(1'b0);
        test_wrap_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
